rega_multizona: RTL

Multi-zone successor to the single-bed irrigation controller: serves NZONES beds from one tank and one pump, picks the next dry zone round-robin, and waters it for a timed interval in sprinkler (A) or drip (G) mode. An optional fertilize-and-flush cycle follows the watering. The block sits under the board top, beside the 7-segment stopwatch, and replaces the single-zone irrigation decision logic and the irrigation-type and fertilizer/cleaning state machines.

---
 rtl/rega_pkg.sv | 19 +
 rtl/rega_multizona_if.sv | 32 +++
 rtl/rega_tick_gen.sv | 31 +++
 rtl/rega_multizona.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rega_pkg.sv
// Shared types and constants for the multi-zone irrigation controller.
package rega_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_WATER  = 3'd2,
        ST_ADUB   = 3'd3,
        ST_LIMP   = 3'd4
    } state_t;

    localparam logic [1:0] NV_EMPTY = 2'b00;
    localparam logic [1:0] NV_LOW   = 2'b01;
    localparam logic [1:0] NV_MID   = 2'b10;
    localparam logic [1:0] NV_FULL  = 2'b11;

    localparam int TIMER_W = 8;

endpackage

// File: rtl/rega_multizona_if.sv
// Sensor inputs and actuator outputs of the irrigation controller.
interface rega_multizona_if #(
    parameter int NZONES = 4
);
    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;

    logic [NZONES-1:0] Us;
    logic [1:0]        Nv;
    logic              Bs;
    logic              Vs;
    logic              Adub;
    logic [NZONES-1:0] Zv;
    logic [ZW-1:0]     Zone;
    logic              A;
    logic              G;
    logic              Ve;
    logic              Mist;
    logic              Limp;
    logic              Busy;
    logic [7:0]        Rem;

    modport master (
        output Us, Nv, Bs, Vs, Adub,
        input  Zv, Zone, A, G, Ve, Mist, Limp, Busy, Rem
    );

    modport slave (
        input  Us, Nv, Bs, Vs, Adub,
        output Zv, Zone, A, G, Ve, Mist, Limp, Busy, Rem
    );

endinterface

// File: rtl/rega_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module rega_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clk,
    input  logic Rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/rega_multizona.sv
// Multi-zone irrigation sequencer: round-robin dry-zone pick, timed watering,
// optional fertilize/flush cycle enabled by MULTIZONA_ADUB_EN.
//
// state  | meaning
// IDLE   | waiting for a dry zone with water available and no rain
// SELECT | latch zone pointer and spray mode, load watering timer
// WATER  | zone valve open, sprinkler (A) or drip (G)
// ADUB   | fertilizer valve and mixer on
// LIMP   | line flush after fertilizing
module rega_multizona
    import rega_pkg::*;
#(
    parameter int NZONES   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int WATER_T  = 10,
    parameter int ADUB_T   = 3,
    parameter int LIMP_T   = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    rega_multizona_if.slave    bus
);
    localparam int ZW = (NZONES > 1) ? $clog2(NZONES) : 1;
    localparam logic [TIMER_W-1:0] WATER_LD = TIMER_W'(WATER_T);
    localparam logic [TIMER_W-1:0] ADUB_LD  = TIMER_W'(ADUB_T);
    localparam logic [TIMER_W-1:0] LIMP_LD  = TIMER_W'(LIMP_T);
    localparam logic [TIMER_W-1:0] ONE      = TIMER_W'(1);

    state_t               state_q, state_d;
    logic [ZW-1:0]        zone_q, zone_d;
    logic [ZW-1:0]        ptr_q, ptr_d;
    logic                 mode_a_q, mode_a_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 adub_pend_q;
    logic                 tick;
    logic                 found;
    logic [ZW-1:0]        cand;
    logic                 expire;
    logic                 abort;
    logic                 valve_open;

    rega_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk  (Clk),
        .Rst  (Rst),
        .tick (tick)
    );

    // Rotating priority search: first dry zone after the last one served.
    always_comb begin
        int idx;
        found = 1'b0;
        cand  = '0;
        idx   = 0;
        for (int i = 1; i <= NZONES; i++) begin
            idx = (int'(ptr_q) + i) % NZONES;
            if (!found && bus.Us[ZW'(idx)]) begin
                found = 1'b1;
                cand  = ZW'(idx);
            end
        end
    end

    // Exit on the tick that would take the timer to zero.
    assign expire = (timer_q == '0) || (tick && timer_q == ONE);
    assign abort  = (bus.Nv == NV_EMPTY) || bus.Bs;

`ifdef MULTIZONA_ADUB_EN
    logic adub_pend_d;

    always_comb begin
        adub_pend_d = adub_pend_q;
        if (state_q == ST_LIMP && expire) begin
            adub_pend_d = 1'b0;
        end
        if (bus.Adub) begin
            adub_pend_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            adub_pend_q <= 1'b0;
        end else begin
            adub_pend_q <= adub_pend_d;
        end
    end
`else
    logic unused_adub;
    assign unused_adub = bus.Adub;
    assign adub_pend_q = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        zone_d   = zone_q;
        ptr_d    = ptr_q;
        mode_a_d = mode_a_q;
        timer_d  = timer_q;
        if (tick && timer_q != '0) begin
            timer_d = timer_q - ONE;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (found && bus.Nv != NV_EMPTY && !bus.Bs) begin
                    state_d = ST_SELECT;
                    zone_d  = cand;
                end
            end
            ST_SELECT: begin
                ptr_d    = zone_q;
                mode_a_d = !bus.Vs && (bus.Nv >= NV_MID);
                timer_d  = WATER_LD;
                state_d  = ST_WATER;
            end
            ST_WATER: begin
                if (bus.Vs) begin
                    mode_a_d = 1'b0;
                end
                if (abort) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (expire) begin
                    if (adub_pend_q) begin
                        state_d = ST_ADUB;
                        timer_d = ADUB_LD;
                    end else begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                end
            end
            ST_ADUB: begin
                if (bus.Vs) begin
                    mode_a_d = 1'b0;
                end
                if (expire) begin
                    state_d = ST_LIMP;
                    timer_d = LIMP_LD;
                end
            end
            ST_LIMP: begin
                if (expire) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            zone_q   <= '0;
            ptr_q    <= ZW'(NZONES - 1);
            mode_a_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            zone_q   <= zone_d;
            ptr_q    <= ptr_d;
            mode_a_q <= mode_a_d;
            timer_q  <= timer_d;
        end
    end

    assign valve_open = (state_q == ST_WATER) || (state_q == ST_ADUB) ||
                        (state_q == ST_LIMP);

    always_comb begin
        bus.Zv   = '0;
        if (valve_open) begin
            bus.Zv = NZONES'(1) << zone_q;
        end
        bus.Zone = zone_q;
        bus.A    = ((state_q == ST_WATER) || (state_q == ST_ADUB)) && mode_a_q;
        bus.G    = ((state_q == ST_WATER) || (state_q == ST_ADUB)) && !mode_a_q;
        bus.Ve   = (state_q == ST_ADUB);
        bus.Mist = (state_q == ST_ADUB);
        bus.Limp = (state_q == ST_LIMP);
        bus.Busy = (state_q != ST_IDLE);
        bus.Rem  = timer_q;
    end

endmodule
